// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/arith/shift ops plus iterative MULU/DIVU (DIVU only with ALU_SEQ_DIV_EN).
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MULU/DIVU; done pulses when outputs update.
// Backpressure: start is ignored while busy=1; a new start is accepted in the done cycle.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       gin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] sum_hi,
  output logic             zout,
  output logic             nout,
  output logic             vout,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MULU = 4'b1010;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1011;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1
`ifdef ALU_SEQ_DIV_EN
    , DIV = 2'd2
`endif
  } state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  // hi/lo hold accumulator:multiplier for MULU and remainder:quotient for DIVU
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;
  logic [SHW-1:0]   shamt;
  logic             slt_r;
  logic [WIDTH-1:0] sc_sum;
  logic             sc_ovf;

  assign add_r = a + b;
  assign sub_r = a - b;
  assign shamt = b[SHW-1:0];
  // Sign comparison first so the result stays correct when a-b overflows
  assign slt_r = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : sub_r[WIDTH-1];

  always_comb begin
    sc_sum = '0;
    sc_ovf = 1'b0;
    case (gin)
      OP_AND: sc_sum = a & b;
      OP_OR:  sc_sum = a | b;
      OP_NOR: sc_sum = ~(a | b);
      OP_ADD: begin
        sc_sum = add_r;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_sum = sub_r;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: sc_sum = {{(WIDTH-1){1'b0}}, slt_r};
      OP_SLL: sc_sum = a << shamt;
      OP_SRL: sc_sum = a >> shamt;
      OP_SRA: sc_sum = $signed(a) >>> shamt;
      default: begin
        sc_sum = '0;
        sc_ovf = 1'b1;
      end
    endcase
  end

  logic [WIDTH:0]   madd;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  assign madd   = {1'b0, hi} + {1'b0, opnd & {WIDTH{lo[0]}}};
  assign mul_hi = madd[WIDTH:1];
  assign mul_lo = {madd[0], lo[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   dshift;
  logic [WIDTH:0]   ddiff;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  // Divide-by-zero needs no special case: every step subtracts, giving all-ones and rem=a
  assign dshift = {hi, lo[WIDTH-1]};
  assign ddiff  = dshift - {1'b0, opnd};
  assign div_ok = ~ddiff[WIDTH];
  assign div_hi = div_ok ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
  assign div_lo = {lo[WIDTH-2:0], div_ok};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      sum    <= '0;
      sum_hi <= '0;
      zout   <= 1'b0;
      nout   <= 1'b0;
      vout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (gin == OP_MULU) begin
              state <= MUL;
              busy  <= 1'b1;
              cnt   <= '0;
              hi    <= '0;
              lo    <= b;
              opnd  <= a;
`ifdef ALU_SEQ_DIV_EN
            end else if (gin == OP_DIVU) begin
              state <= DIV;
              busy  <= 1'b1;
              cnt   <= '0;
              hi    <= '0;
              lo    <= a;
              opnd  <= b;
`endif
            end else begin
              sum    <= sc_sum;
              sum_hi <= '0;
              vout   <= sc_ovf;
              zout   <= (sc_sum == '0);
              nout   <= sc_sum[WIDTH-1];
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          hi  <= mul_hi;
          lo  <= mul_lo;
          cnt <= cnt + SHW'(1);
          if (cnt == LAST) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            sum    <= mul_lo;
            sum_hi <= mul_hi;
            vout   <= |mul_hi;
            zout   <= (mul_lo == '0);
            nout   <= mul_lo[WIDTH-1];
          end
        end
`ifdef ALU_SEQ_DIV_EN
        DIV: begin
          hi  <= div_hi;
          lo  <= div_lo;
          cnt <= cnt + SHW'(1);
          if (cnt == LAST) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            sum    <= div_lo;
            sum_hi <= div_hi;
            vout   <= (opnd == '0);
            zout   <= (div_lo == '0);
            nout   <= div_lo[WIDTH-1];
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
